sram_ahb_arbiter: RTL and testbench

Two-master arbiter sharing the single-port SRAM AHB slave between the scalar core data port (m0) and the vector load/store unit (m1). It sits between both masters and the SRAM wrapper. It serialises their transactions, latches the winning address, control and write data, and holds the slave select until the slave signals completion. It returns read data and response to the winner only. A timeout turns a hung slave access into an AHB ERROR.

---
 rtl/sram_ahb_arbiter.sv | 175 +++++++++++++++++
 tb/tb_sram_ahb_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ahb_arbiter.sv
// sram_ahb_arbiter: two-master arbiter in front of the single-port SRAM AHB slave.
// Ports: hclk_i/hresetn_i; m0_*/m1_* master side (hsel, haddr, hwrite, hsize,
// hwdata in; hrdata, hready, hresp out); s_* slave side; grant_o one-hot owner.
module sram_ahb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 16
) (
  input  logic                  hclk_i,
  input  logic                  hresetn_i,
  input  logic                  m0_hsel_i,
  input  logic [DATA_WIDTH-1:0] m0_haddr_i,
  input  logic                  m0_hwrite_i,
  input  logic [2:0]            m0_hsize_i,
  input  logic [DATA_WIDTH-1:0] m0_hwdata_i,
  output logic [DATA_WIDTH-1:0] m0_hrdata_o,
  output logic                  m0_hready_o,
  output logic [1:0]            m0_hresp_o,
  input  logic                  m1_hsel_i,
  input  logic [DATA_WIDTH-1:0] m1_haddr_i,
  input  logic                  m1_hwrite_i,
  input  logic [2:0]            m1_hsize_i,
  input  logic [DATA_WIDTH-1:0] m1_hwdata_i,
  output logic [DATA_WIDTH-1:0] m1_hrdata_o,
  output logic                  m1_hready_o,
  output logic [1:0]            m1_hresp_o,
  output logic                  s_hsel_o,
  output logic [DATA_WIDTH-1:0] s_haddr_o,
  output logic                  s_hwrite_o,
  output logic [2:0]            s_hsize_o,
  output logic [DATA_WIDTH-1:0] s_hwdata_o,
  input  logic [DATA_WIDTH-1:0] s_hrdata_i,
  input  logic                  s_hready_i,
  input  logic [1:0]            s_hresp_i,
  output logic [1:0]            grant_o
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DONE
  } state_t;

  localparam logic [7:0] CNT_LIM = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic                  last_q, last_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  sel_q, sel_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic                  pick_m1;

  // last_q = 1 means m1 was served last; a tie goes to the other one
  always_comb begin
    pick_m1 = 1'b0;
    if (m1_hsel_i && !m0_hsel_i) begin
      pick_m1 = 1'b1;
    end else if (m1_hsel_i && m0_hsel_i) begin
      pick_m1 = (FIXED_PRIO == 0) && !last_q;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    unique case (state_q)
      IDLE: begin
        if (m0_hsel_i || m1_hsel_i) begin
          sel_d   = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
          if (pick_m1) begin
            grant_d = 2'b10;
            addr_d  = m1_haddr_i;
            write_d = m1_hwrite_i;
            size_d  = m1_hsize_i;
            wdata_d = m1_hwdata_i;
          end else begin
            grant_d = 2'b01;
            addr_d  = m0_haddr_i;
            write_d = m0_hwrite_i;
            size_d  = m0_hsize_i;
            wdata_d = m0_hwdata_i;
          end
        end
      end
      GRANT: begin
        cnt_d = cnt_q + 8'd1;
        // a real completion wins over a timeout in the same cycle
        if (s_hready_i) begin
          rdata_d = s_hrdata_i;
          resp_d  = s_hresp_i;
          sel_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LIM) begin
          rdata_d = '0;
          resp_d  = 2'b01;
          sel_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = grant_q[1];
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: begin
        sel_d   = 1'b0;
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  logic done;
  assign done = (state_q == DONE);

  assign m0_hready_o = done && grant_q[0];
  assign m1_hready_o = done && grant_q[1];
  assign m0_hrdata_o = m0_hready_o ? rdata_q : '0;
  assign m1_hrdata_o = m1_hready_o ? rdata_q : '0;
  assign m0_hresp_o  = m0_hready_o ? resp_q : 2'b00;
  assign m1_hresp_o  = m1_hready_o ? resp_q : 2'b00;

  assign s_hsel_o   = sel_q;
  assign s_haddr_o  = addr_q;
  assign s_hwrite_o = write_q;
  assign s_hsize_o  = size_q;
  assign s_hwdata_o = wdata_q;
  assign grant_o    = grant_q;

endmodule

// File: tb/tb_sram_ahb_arbiter.sv
// tb_sram_ahb_arbiter: directed bench for sram_ahb_arbiter.
// dut_a is round-robin, dut_b fixed-priority; both share master stimulus.
module tb_sram_ahb_arbiter;
  localparam int DW = 32;

  logic hclk = 1'b0;
  logic hresetn;
  always #5 hclk = ~hclk;

  logic          m0_hsel, m0_hwrite, m1_hsel, m1_hwrite;
  logic [DW-1:0] m0_haddr, m0_hwdata, m1_haddr, m1_hwdata;
  logic [2:0]    m0_hsize, m1_hsize;

  logic [DW-1:0] a_m0_hrdata, a_m1_hrdata, b_m0_hrdata, b_m1_hrdata;
  logic          a_m0_hready, a_m1_hready, b_m0_hready, b_m1_hready;
  logic [1:0]    a_m0_hresp, a_m1_hresp, b_m0_hresp, b_m1_hresp;
  logic          a_s_hsel, a_s_hwrite, b_s_hsel, b_s_hwrite;
  logic [DW-1:0] a_s_haddr, a_s_hwdata, b_s_haddr, b_s_hwdata;
  logic [2:0]    a_s_hsize, b_s_hsize;
  logic          a_s_hready, b_s_hready;
  logic [1:0]    a_grant, b_grant;

  // slave model: answers lat cycles into the access, lat==0 never answers
  int            lat = 3;
  logic [DW-1:0] srd = 32'hDEAD_BEEF;
  logic [1:0]    srsp = 2'b00;
  int            a_wcnt = 0;
  int            b_wcnt = 0;

  always @(posedge hclk) a_wcnt <= a_s_hsel ? a_wcnt + 1 : 0;
  always @(posedge hclk) b_wcnt <= b_s_hsel ? b_wcnt + 1 : 0;
  assign a_s_hready = a_s_hsel && (lat != 0) && (a_wcnt == lat - 1);
  assign b_s_hready = b_s_hsel && (lat != 0) && (b_wcnt == lat - 1);

  sram_ahb_arbiter #(.DATA_WIDTH(DW), .FIXED_PRIO(0), .TIMEOUT(16)) dut_a (
    .hclk_i(hclk), .hresetn_i(hresetn),
    .m0_hsel_i(m0_hsel), .m0_haddr_i(m0_haddr), .m0_hwrite_i(m0_hwrite),
    .m0_hsize_i(m0_hsize), .m0_hwdata_i(m0_hwdata),
    .m0_hrdata_o(a_m0_hrdata), .m0_hready_o(a_m0_hready),
    .m0_hresp_o(a_m0_hresp),
    .m1_hsel_i(m1_hsel), .m1_haddr_i(m1_haddr), .m1_hwrite_i(m1_hwrite),
    .m1_hsize_i(m1_hsize), .m1_hwdata_i(m1_hwdata),
    .m1_hrdata_o(a_m1_hrdata), .m1_hready_o(a_m1_hready),
    .m1_hresp_o(a_m1_hresp),
    .s_hsel_o(a_s_hsel), .s_haddr_o(a_s_haddr), .s_hwrite_o(a_s_hwrite),
    .s_hsize_o(a_s_hsize), .s_hwdata_o(a_s_hwdata),
    .s_hrdata_i(srd), .s_hready_i(a_s_hready), .s_hresp_i(srsp),
    .grant_o(a_grant)
  );

  sram_ahb_arbiter #(.DATA_WIDTH(DW), .FIXED_PRIO(1), .TIMEOUT(16)) dut_b (
    .hclk_i(hclk), .hresetn_i(hresetn),
    .m0_hsel_i(m0_hsel), .m0_haddr_i(m0_haddr), .m0_hwrite_i(m0_hwrite),
    .m0_hsize_i(m0_hsize), .m0_hwdata_i(m0_hwdata),
    .m0_hrdata_o(b_m0_hrdata), .m0_hready_o(b_m0_hready),
    .m0_hresp_o(b_m0_hresp),
    .m1_hsel_i(m1_hsel), .m1_haddr_i(m1_haddr), .m1_hwrite_i(m1_hwrite),
    .m1_hsize_i(m1_hsize), .m1_hwdata_i(m1_hwdata),
    .m1_hrdata_o(b_m1_hrdata), .m1_hready_o(b_m1_hready),
    .m1_hresp_o(b_m1_hresp),
    .s_hsel_o(b_s_hsel), .s_haddr_o(b_s_haddr), .s_hwrite_o(b_s_hwrite),
    .s_hsize_o(b_s_hsize), .s_hwdata_o(b_s_hwdata),
    .s_hrdata_i(srd), .s_hready_i(b_s_hready), .s_hresp_i(srsp),
    .grant_o(b_grant)
  );

  int         checks = 0;
  int         errors = 0;
  int         a_p0 = 0;
  int         a_p1 = 0;
  int         ovl = 0;
  logic [1:0] prev_g = 2'b00;
  logic [1:0] gq[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one edge, sample 1ns later, keep pulse/grant bookkeeping
  task automatic step();
    @(posedge hclk);
    #1;
    if (a_m0_hready) a_p0++;
    if (a_m1_hready) a_p1++;
    if (a_m1_hready && a_grant == 2'b01) ovl++;
    if (a_grant != 2'b00 && prev_g == 2'b00) gq.push_back(a_grant);
    prev_g = a_grant;
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0: return a_m0_hready;
      1: return a_m1_hready;
      2: return b_m0_hready;
      default: return b_m1_hready;
    endcase
  endfunction

  task automatic wait_rdy(input int sel, output int n);
    bit got;
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      n++;
      if (rdy(sel)) got = 1'b1;
    end
    if (!got) n = -1;
  endtask

  function automatic logic [1:0] gq_at(input int k);
    if (gq.size() > k) return gq[k];
    return 2'b11;
  endfunction

  initial begin
    int n;
    bit got;
    hresetn = 1'b0;
    m0_hsel = 0; m0_hwrite = 0; m0_haddr = '0; m0_hwdata = '0; m0_hsize = '0;
    m1_hsel = 0; m1_hwrite = 0; m1_haddr = '0; m1_hwdata = '0; m1_hsize = '0;

    // reset state
    #7;
    chk("rst_s_hsel", a_s_hsel, 0);
    chk("rst_grant", a_grant, 0);
    chk("rst_m0_hready", a_m0_hready, 0);
    chk("rst_m1_hready", a_m1_hready, 0);
    chk("rst_s_haddr", a_s_haddr, 0);
    chk("rst_s_hwdata", a_s_hwdata, 0);
    chk("rst_m0_hresp", a_m0_hresp, 0);
    chk("rst_m1_hrdata", a_m1_hrdata, 0);
    #3;
    hresetn = 1'b1;
    step();

    // single read by m0, slave answers in the 3rd GRANT cycle
    lat = 3; srd = 32'hDEAD_BEEF;
    a_p0 = 0;
    m0_hsel = 1; m0_haddr = 32'h40; m0_hsize = 3'b010;
    step();
    chk("rd_grant", a_grant, 2'b01);
    chk("rd_s_hsel", a_s_hsel, 1);
    chk("rd_s_haddr", a_s_haddr, 32'h40);
    chk("rd_s_hwrite", a_s_hwrite, 0);
    chk("rd_s_hsize", a_s_hsize, 3'b010);
    wait_rdy(0, n);
    chk("rd_latency", n, 3);
    chk("rd_hrdata", a_m0_hrdata, 32'hDEAD_BEEF);
    chk("rd_hresp", a_m0_hresp, 2'b00);
    chk("rd_m1_hrdata_zero", a_m1_hrdata, 0);
    m0_hsel = 0;
    step();
    chk("rd_hready_drop", a_m0_hready, 0);
    chk("rd_grant_clr", a_grant, 2'b00);
    chk("rd_s_hsel_drop", a_s_hsel, 0);
    chk("rd_pulses", a_p0, 1);

    // m1 write; master data changes after grant must not reach the slave
    lat = 4;
    m1_hsel = 1; m1_haddr = 32'h100; m1_hwrite = 1; m1_hwdata = 32'h1234_5678;
    step();
    chk("wr_grant", a_grant, 2'b10);
    chk("wr_s_haddr", a_s_haddr, 32'h100);
    chk("wr_s_hwrite", a_s_hwrite, 1);
    chk("wr_s_hwdata", a_s_hwdata, 32'h1234_5678);
    m1_hwdata = '0;
    n = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      n++;
      chk("wr_hold_hwdata", a_s_hwdata, 32'h1234_5678);
      chk("wr_m0_quiet", a_m0_hready, 0);
      if (a_m1_hready) got = 1;
    end
    chk("wr_latency", n, 4);
    m1_hsel = 0; m1_hwrite = 0;
    step();

    // both held: round-robin must alternate starting with m0
    lat = 1;
    a_p0 = 0; a_p1 = 0; ovl = 0; gq.delete();
    m0_hsel = 1; m0_haddr = 32'h200;
    m1_hsel = 1; m1_haddr = 32'h300;
    for (int i = 0; i < 60 && (a_p0 < 2 || a_p1 < 2); i++) begin
      step();
      if (a_m0_hready && a_p0 == 2) m0_hsel = 0;
      if (a_m1_hready && a_p1 == 2) m1_hsel = 0;
    end
    m0_hsel = 0; m1_hsel = 0;
    step();
    step();
    chk("rr_ngrants", gq.size(), 4);
    chk("rr_g0", gq_at(0), 2'b01);
    chk("rr_g1", gq_at(1), 2'b10);
    chk("rr_g2", gq_at(2), 2'b01);
    chk("rr_g3", gq_at(3), 2'b10);
    chk("rr_m0_pulses", a_p0, 2);
    chk("rr_m1_pulses", a_p1, 2);
    chk("rr_overlap", ovl, 0);

    // silent slave: ERROR completion in cycle 17 after the grant edge
    lat = 0; srd = 32'hFFFF_FFFF;
    m0_hsel = 1; m0_haddr = 32'h80;
    step();
    chk("to_grant", a_grant, 2'b01);
    wait_rdy(0, n);
    chk("to_latency", n, 16);
    chk("to_hresp", a_m0_hresp, 2'b01);
    chk("to_hrdata", a_m0_hrdata, 0);
    // request kept high is served again after one IDLE cycle
    lat = 2; srd = 32'hA5A5_0001;
    m0_haddr = 32'h84;
    wait_rdy(0, n);
    chk("to_next_latency", n, 4);
    chk("to_next_hresp", a_m0_hresp, 2'b00);
    chk("to_next_hrdata", a_m0_hrdata, 32'hA5A5_0001);
    chk("to_next_haddr", a_s_haddr, 32'h84);
    m0_hsel = 0;
    step();

    // async reset two cycles into an m1 access
    lat = 0; a_p1 = 0;
    m1_hsel = 1; m1_haddr = 32'h400;
    step();
    chk("rg_grant", a_grant, 2'b10);
    step();
    step();
    #2;
    hresetn = 1'b0;
    #1;
    chk("rg_s_hsel_async", a_s_hsel, 0);
    chk("rg_grant_async", a_grant, 2'b00);
    m0_hsel = 1; m0_haddr = 32'h500;
    step();
    step();
    hresetn = 1'b1;
    chk("rg_no_m1_pulse", a_p1, 0);
    lat = 1;
    step();
    chk("rg_tie_m0", a_grant, 2'b01);
    chk("rg_tie_haddr", a_s_haddr, 32'h500);
    wait_rdy(0, n);
    chk("rg_latency", n, 1);
    m0_hsel = 0; m1_hsel = 0;
    step();
    step();

    // fixed priority: m1 starves while m0 keeps requesting
    hresetn = 1'b0;
    step();
    hresetn = 1'b1;
    lat = 1;
    m0_hsel = 1; m0_haddr = 32'h700;
    m1_hsel = 1; m1_haddr = 32'h600;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("fp_no_m1", b_grant[1], 0);
    end
    wait_rdy(2, n);
    chk("fp_m0_done", n > 0, 1);
    m0_hsel = 0;
    step();
    chk("fp_idle", b_grant, 2'b00);
    step();
    chk("fp_m1_grant", b_grant, 2'b10);
    chk("fp_m1_haddr", b_s_haddr, 32'h600);
    wait_rdy(3, n);
    chk("fp_m1_latency", n, 1);
    m1_hsel = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
